l_counter_stack: RTL and testbench
==================================

# l_counter_stack

Parametrised program/loop counter for the MachineV datapath with a hardware return stack. It loads from and drives the shared address bus, increments by a configurable step, and adds a signed bus offset for relative jumps. With the stack compiled in, it executes call/return. It replaces the fixed 5-bit load/increment counter and sits between the control unit's micro-op decoder and the A bus.

## Interface
- WIDTH, 5: counter and bus width in bits.
- DEPTH, 4: return-stack entries; must be ≥ 1.
- STEP, 1: increment amount, taken modulo 2^WIDTH.
- CLK  in  1: clock; all state updates on the rising edge.
- nRST  in  1: asynchronous, active-low reset.
- Lin  in  1: load L from Abus.
- Lout  in  1: drive L onto Abus.
- inc  in  1: L <= L + STEP.
- rel  in  1: L <= L + Abus, with Abus read as two's complement.
- call  in  1: push L + STEP, then L <= Abus.
- ret  in  1: pop top of stack into L.
- clr_err  in  1: clear the sticky err flag.
- Abus  inout  WIDTH: shared address bus; high-Z unless Lout = 1.
- L  out  WIDTH: current counter value.
- wrap  out  1: registered one-cycle pulse when inc or rel crosses the modulo boundary (carry out of bit WIDTH-1).
- empty  out  1: stack holds 0 entries.
- full  out  1: stack holds DEPTH entries.
- err  out  1: sticky fault flag.

## Operation
- Abus = Lout ? L : high-Z. This path is combinational.
- Command priority per cycle, highest first: ret, call, Lin, rel, inc. Only the winning command takes effect.
- Lout together with any bus-reading command (Lin, rel, call):
  - The counter reads its own value.
  - Lin then leaves L unchanged; rel doubles L; call jumps to L.
  - This is legal and is not an error.
- Stack: DEPTH×WIDTH register array plus a stack pointer sp (0..DEPTH). empty = (sp == 0); full = (sp == DEPTH).
- call when not full:
  - stack[sp] <= L + STEP (modulo).
  - sp <= sp + 1.
  - L <= Abus.
- call when full: L, sp and stack are unchanged; err <= 1.
- ret when not empty: L <= stack[sp-1]; sp <= sp - 1.
- ret when empty: no state change; err <= 1.
- call and ret asserted together: neither executes, Lin/rel/inc are also suppressed, and err <= 1.
- Arithmetic wraps modulo 2^WIDTH.
  - wrap <= 1 for inc when the unsigned sum L + STEP ≥ 2^WIDTH.
  - wrap <= 1 for rel when the unsigned sum of L and Abus ≥ 2^WIDTH.
  - wrap <= 0 in every other cycle.
- err clears only via clr_err or nRST. If clr_err coincides with a new fault, set wins.

## Timing
- Reset (nRST low, asynchronous): L = 0, sp = 0, empty = 1, full = 0, err = 0, wrap = 0. Stack contents need not be cleared.
- Reset asserted mid-operation aborts any command in that cycle. The first edge after nRST rises executes normally.
- Latency is one cycle for every command: the new L, sp, flags and wrap are visible after the edge that samples the command.
- Lout-to-Abus is zero-cycle combinational. The bus master guarantees no other driver while Lout = 1.
- The stack top written by call is readable by a ret on the very next cycle.

## Configuration
- LSTACK_EN defined:
  - Return stack, call, ret, empty, full and stack-fault err are present as described above.
- LSTACK_EN undefined:
  - No stack storage is built; call and ret are ignored (treated as 0).
  - empty = 1, full = 0, err = 0 constant; clr_err is unused.
  - Lin, rel, inc, Lout and wrap are unchanged.

## Test plan
- WIDTH = 5, STEP = 1: reset, then 32 inc cycles → L steps 0, 1, … 31, 0; wrap pulses exactly once, in the cycle after the 31 → 0 edge.
- L = 10, Abus = 5'b11101 (-3), rel → L = 7, wrap = 1. Then Abus = 2, rel → L = 9, wrap = 0.
- Stack path, DEPTH = 4:
  - L = 3, Abus = 20, call → L = 20, stack top = 4, empty = 0.
  - ret → L = 4, empty = 1.
- DEPTH = 4:
  - Four calls → full = 1.
  - A fifth call with Abus = 9 → L unchanged, err = 1.
  - Four rets → empty = 1; a fifth ret → L unchanged, err stays 1.
  - clr_err → err = 0.
- Priority and simultaneity:
  - Lin + inc with Abus = 12 → L = 12.
  - call + ret together → no change, err = 1.
  - Lin + Lout → L unchanged, Abus equals L.
- nRST pulse asynchronously between edges while sp = 2, L = 17 → L = 0, empty = 1, err = 0 immediately. Without LSTACK_EN, call is ignored and empty stays 1.

Source files
------------

// File: rtl/l_counter_stack_if.sv
// l_counter_stack_if: command and status bundle of the MachineV program/loop
// counter. The shared address bus Abus is not part of this bundle: it is a
// resolved tri-state net and stays a plain inout port on the counter itself.
//
// Command semantics (no valid/ready pairing): every command line is sampled
// on each rising clock edge, and the highest-priority asserted command takes
// effect on that edge. There is no back-pressure. Status outputs are
// registered or decoded from registers, and are valid right after the edge.
//
//   master (control unit) drives : Lin, Lout, inc, rel, call, ret, clr_err
//   slave  (counter) drives      : L, wrap, empty, full, err, sp (debug: stack pointer)
interface l_counter_stack_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             Lin;
  logic             Lout;
  logic             inc;
  logic             rel;
  logic             call;
  logic             ret;
  logic             clr_err;
  logic [WIDTH-1:0] L;
  logic             wrap;
  logic             empty;
  logic             full;
  logic             err;
  logic [SPW-1:0]   sp;

  modport master (
    output Lin, Lout, inc, rel, call, ret, clr_err,
    input  L, wrap, empty, full, err, sp
  );

  modport slave (
    input  Lin, Lout, inc, rel, call, ret, clr_err,
    output L, wrap, empty, full, err, sp
  );
endinterface

// File: rtl/l_counter_stack.sv
// l_counter_stack: parametrised program/loop counter with an optional
// hardware return stack.
//
// Compile-time option: define LSTACK_EN to build the return stack. When the
// macro is absent, call/ret/clr_err are ignored, empty=1, full=0, err=0 and
// the debug stack pointer reads 0.
//
// Ports:
//   CLK   - clock; all state updates on the rising edge
//   nRST  - asynchronous active-low reset
//   Abus  - shared address bus; driven with L while Lout=1, high-Z otherwise
//   bus   - l_counter_stack_if.slave (commands in, L/wrap/empty/full/err/sp out)
//
// Command priority, highest first: ret, call, Lin, rel, inc.
// When call and ret are asserted together, nothing executes and err is set.
module l_counter_stack #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  inout  wire  [WIDTH-1:0] Abus,
  l_counter_stack_if.slave bus
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] l_q, l_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] bus_val;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   rel_sum;
  logic             stack_cmd;

  assign Abus = bus.Lout ? l_q : {WIDTH{1'bz}};

  // While the counter drives the bus it reads its own value. Taking l_q
  // directly keeps this independent of how the tri-state net resolves.
  assign bus_val = bus.Lout ? l_q : Abus;

  // The extra top bit is the carry out of bit WIDTH-1, which becomes wrap.
  assign inc_sum = {1'b0, l_q} + {1'b0, STEP_W};
  assign rel_sum = {1'b0, l_q} + {1'b0, bus_val};

`ifdef LSTACK_EN
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   top_idx;
  logic             err_q, err_d;
  logic             push;

  assign stack_cmd = bus.call | bus.ret;
  assign top_idx   = sp_q - 1'b1;

  always_comb begin
    sp_d  = sp_q;
    push  = 1'b0;
    // A fault raised in the same cycle as clr_err overrides the clear below.
    err_d = err_q & ~bus.clr_err;
    if (bus.call && bus.ret) begin
      err_d = 1'b1;
    end else if (bus.ret) begin
      if (sp_q == '0) err_d = 1'b1;
      else            sp_d  = sp_q - 1'b1;
    end else if (bus.call) begin
      if (sp_q == SP_FULL) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        sp_d = sp_q + 1'b1;
      end
    end
  end

  // Stack contents are not reset; only sp defines which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) stack_q[sp_q[IW-1:0]] <= inc_sum[WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign bus.sp    = sp_q;
  assign bus.empty = (sp_q == '0);
  assign bus.full  = (sp_q == SP_FULL);
  assign bus.err   = err_q;
`else
  logic unused_stack_inputs;

  assign stack_cmd           = 1'b0;
  assign unused_stack_inputs = &{1'b0, bus.call, bus.ret, bus.clr_err};
  assign bus.sp              = '0;
  assign bus.empty           = 1'b1;
  assign bus.full            = 1'b0;
  assign bus.err             = 1'b0;
`endif

  always_comb begin
    l_d    = l_q;
    wrap_d = 1'b0;
`ifdef LSTACK_EN
    if (bus.call && bus.ret) begin
      l_d = l_q;
    end else if (bus.ret) begin
      if (sp_q != '0) l_d = stack_q[top_idx[IW-1:0]];
    end else if (bus.call) begin
      if (sp_q != SP_FULL) l_d = bus_val;
    end
`endif
    if (!stack_cmd) begin
      if (bus.Lin)      l_d = bus_val;
      else if (bus.rel) {wrap_d, l_d} = rel_sum;
      else if (bus.inc) {wrap_d, l_d} = inc_sum;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      l_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      l_q    <= l_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.L    = l_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_l_counter_stack.sv
module tb_l_counter_stack;

  logic       CLK;
  logic       nRST;
  logic [4:0] abus_drv;
  logic       abus_en;
  wire  [4:0] abus;
  int         total;
  int         bad;

  assign abus = abus_en ? abus_drv : 5'bzzzzz;

  l_counter_stack_if #(.WIDTH(5), .DEPTH(4)) bus_if ();

  l_counter_stack #(.WIDTH(5), .DEPTH(4), .STEP(1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .Abus (abus),
    .bus  (bus_if)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic idle();
    bus_if.Lin     = 1'b0;
    bus_if.Lout    = 1'b0;
    bus_if.inc     = 1'b0;
    bus_if.rel     = 1'b0;
    bus_if.call    = 1'b0;
    bus_if.ret     = 1'b0;
    bus_if.clr_err = 1'b0;
    abus_en        = 1'b0;
    abus_drv       = 5'd0;
  endtask

  task automatic drive(input logic [4:0] v);
    abus_en  = 1'b1;
    abus_drv = v;
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    nRST = 1'b0;
    #12;
    chk("rst_L", 32'(bus_if.L), 0);
    chk("rst_empty", 32'(bus_if.empty), 1);
    chk("rst_full", 32'(bus_if.full), 0);
    chk("rst_err", 32'(bus_if.err), 0);
    chk("rst_wrap", 32'(bus_if.wrap), 0);
    @(negedge CLK);
    nRST = 1'b1;

    // 32 increments: 1..31 then 0, wrap only after the 31->0 edge
    bus_if.inc = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("inc_L", 32'(bus_if.L), 32'(i % 32));
      chk("inc_wrap", 32'(bus_if.wrap), (i == 32) ? 32'd1 : 32'd0);
    end
    idle();
    step();
    chk("idle_L", 32'(bus_if.L), 0);
    chk("idle_wrap", 32'(bus_if.wrap), 0);

    // relative jumps
    drive(5'd10); bus_if.Lin = 1'b1;
    step(); idle();
    chk("lin_L", 32'(bus_if.L), 10);
    drive(5'b11101); bus_if.rel = 1'b1;
    step(); idle();
    chk("relneg_L", 32'(bus_if.L), 7);
    chk("relneg_wrap", 32'(bus_if.wrap), 1);
    drive(5'd2); bus_if.rel = 1'b1;
    step(); idle();
    chk("relpos_L", 32'(bus_if.L), 9);
    chk("relpos_wrap", 32'(bus_if.wrap), 0);

    // Lin beats inc
    drive(5'd12); bus_if.Lin = 1'b1; bus_if.inc = 1'b1;
    step(); idle();
    chk("lin_inc_L", 32'(bus_if.L), 12);
    chk("lin_inc_wrap", 32'(bus_if.wrap), 0);

    // self-read while driving the bus
    bus_if.Lout = 1'b1; bus_if.Lin = 1'b1;
    #1;
    chk("lout_abus", 32'(abus), 12);
    step(); idle();
    chk("lin_lout_L", 32'(bus_if.L), 12);
    bus_if.Lout = 1'b1; bus_if.rel = 1'b1;
    step();
    chk("rel_lout_L", 32'(bus_if.L), 24);
    chk("rel_lout_wrap", 32'(bus_if.wrap), 0);
    chk("lout_abus2", 32'(abus), 24);
    step(); idle();
    chk("rel_lout2_L", 32'(bus_if.L), 16);
    chk("rel_lout2_wrap", 32'(bus_if.wrap), 1);

`ifdef LSTACK_EN
    drive(5'd3); bus_if.Lin = 1'b1;
    step(); idle();
    drive(5'd20); bus_if.call = 1'b1;
    step(); idle();
    chk("call_L", 32'(bus_if.L), 20);
    chk("call_empty", 32'(bus_if.empty), 0);
    chk("call_sp", 32'(bus_if.sp), 1);
    bus_if.ret = 1'b1;
    step(); idle();
    chk("ret_L", 32'(bus_if.L), 4);
    chk("ret_empty", 32'(bus_if.empty), 1);

    // fill: pushes 5, 9, 17, 25
    drive(5'd8);  bus_if.call = 1'b1; step(); idle();
    drive(5'd16); bus_if.call = 1'b1; step(); idle();
    drive(5'd24); bus_if.call = 1'b1; step(); idle();
    chk("fill3_full", 32'(bus_if.full), 0);
    drive(5'd30); bus_if.call = 1'b1; step(); idle();
    chk("fill4_L", 32'(bus_if.L), 30);
    chk("fill4_full", 32'(bus_if.full), 1);
    chk("fill4_err", 32'(bus_if.err), 0);
    drive(5'd9); bus_if.call = 1'b1; step(); idle();
    chk("ovf_L", 32'(bus_if.L), 30);
    chk("ovf_err", 32'(bus_if.err), 1);
    chk("ovf_sp", 32'(bus_if.sp), 4);
    bus_if.ret = 1'b1; step(); chk("pop1_L", 32'(bus_if.L), 25);
    step(); chk("pop2_L", 32'(bus_if.L), 17);
    step(); chk("pop3_L", 32'(bus_if.L), 9);
    step(); chk("pop4_L", 32'(bus_if.L), 5);
    chk("pop4_empty", 32'(bus_if.empty), 1);
    step(); idle();
    chk("unf_L", 32'(bus_if.L), 5);
    chk("unf_err", 32'(bus_if.err), 1);
    bus_if.clr_err = 1'b1; step(); idle();
    chk("clr_err", 32'(bus_if.err), 0);

    // call+ret together, with Lin also asserted
    drive(5'd1); bus_if.call = 1'b1; bus_if.ret = 1'b1; bus_if.Lin = 1'b1;
    step(); idle();
    chk("both_L", 32'(bus_if.L), 5);
    chk("both_err", 32'(bus_if.err), 1);
    chk("both_sp", 32'(bus_if.sp), 0);
    bus_if.clr_err = 1'b1; step(); idle();
    chk("clr_err2", 32'(bus_if.err), 0);
    // new fault in the same cycle as clr_err: set wins
    bus_if.clr_err = 1'b1; bus_if.ret = 1'b1; step(); idle();
    chk("clr_vs_fault", 32'(bus_if.err), 1);

    // sp=2, L=17, err=1, then asynchronous reset between edges
    drive(5'd10); bus_if.call = 1'b1; step(); idle();
    drive(5'd17); bus_if.call = 1'b1; step(); idle();
    chk("pre_rst_sp", 32'(bus_if.sp), 2);
    chk("pre_rst_L", 32'(bus_if.L), 17);
    #2 nRST = 1'b0;
    #1;
    chk("arst_L", 32'(bus_if.L), 0);
    chk("arst_empty", 32'(bus_if.empty), 1);
    chk("arst_err", 32'(bus_if.err), 0);
    chk("arst_sp", 32'(bus_if.sp), 0);
`else
    // stack absent: call/ret ignored
    drive(5'd20); bus_if.call = 1'b1;
    step(); idle();
    chk("nostk_call_L", 32'(bus_if.L), 16);
    chk("nostk_empty", 32'(bus_if.empty), 1);
    chk("nostk_err", 32'(bus_if.err), 0);
    drive(5'd7); bus_if.call = 1'b1; bus_if.Lin = 1'b1;
    step(); idle();
    chk("nostk_call_lin_L", 32'(bus_if.L), 7);
    bus_if.ret = 1'b1; bus_if.inc = 1'b1;
    step(); idle();
    chk("nostk_ret_inc_L", 32'(bus_if.L), 8);
    chk("nostk_full", 32'(bus_if.full), 0);
    #2 nRST = 1'b0;
    #1;
    chk("arst_L", 32'(bus_if.L), 0);
    chk("arst_empty", 32'(bus_if.empty), 1);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    bus_if.inc = 1'b1;
    step(); idle();
    chk("post_rst_inc_L", 32'(bus_if.L), 1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
